// File: rtl/rtc_pkg.sv
// Shared types and constants for the BCD real-time clock.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rtc_pkg;

  // One BCD digit, 0..9 in normal use.
  typedef logic [3:0] bcd_t;

  // Seven-segment patterns in active-high form, bit 6 = a ... bit 0 = g.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Largest legal two-digit BCD values for hours and for minutes/seconds.
  localparam logic [7:0] BCD_HH_MAX = 8'h23;
  localparam logic [7:0] BCD_MS_MAX = 8'h59;

  // True when both nibbles are decimal digits and the value does not exceed
  // the limit; BCD with valid nibbles orders the same as plain binary.
  function automatic logic bcd_ok(input logic [7:0] value, input logic [7:0] limit);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= limit);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Converts one BCD digit to a seven-segment pattern with optional blanking.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output always follows the inputs.
module bcd_to_seg7
  import rtc_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  bcd_t       digit,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  // Look up the active-high pattern; codes above 9 never occur but show blank.
  always_comb begin
    pattern = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    pattern = SEG_0;
        4'd1:    pattern = SEG_1;
        4'd2:    pattern = SEG_2;
        4'd3:    pattern = SEG_3;
        4'd4:    pattern = SEG_4;
        4'd5:    pattern = SEG_5;
        4'd6:    pattern = SEG_6;
        4'd7:    pattern = SEG_7;
        4'd8:    pattern = SEG_8;
        4'd9:    pattern = SEG_9;
        default: pattern = SEG_BLANK;
      endcase
    end
  end

  assign seg = ACTIVE_LOW ? ~pattern : pattern;

endmodule

// File: rtl/rtc_bcd_alarm.sv
// BCD real-time clock with 1 Hz prescaler, validated time set, 12/24h display and one-shot alarm.
// Latency: segments/pm combinational from time registers; tick_sec/alarm_irq/set_err one cycle after the edge.
// Backpressure: none; set_valid is sampled every edge and the clock free-runs.
module rtc_bcd_alarm
  import rtc_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       mode_12h,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  output logic [6:0] hrm,
  output logic [6:0] hrl,
  output logic [6:0] min_m,
  output logic [6:0] min_l,
  output logic [6:0] sec_m,
  output logic [6:0] sec_l,
  output logic       pm,
  output logic       tick_sec,
  output logic       alarm_irq,
  output logic       set_err
);

  // A 1 Hz prescaler with CLK_HZ=1 still needs a one-bit register.
  localparam int             PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PCNT_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] pcnt;
  bcd_t hr_t, hr_u, mn_t, mn_u, sc_t, sc_u;
  bcd_t n_hr_t, n_hr_u, n_mn_t, n_mn_u, n_sc_t, n_sc_u;

  logic advance;
  logic set_ok;
  logic alarm_ok;
  logic alarm_hit;

  assign advance  = (pcnt == PCNT_MAX);
  assign set_ok   = bcd_ok(set_hh, BCD_HH_MAX) && bcd_ok(set_mm, BCD_MS_MAX) &&
                    bcd_ok(set_ss, BCD_MS_MAX);
  assign alarm_ok = bcd_ok(alarm_hh, BCD_HH_MAX) && bcd_ok(alarm_mm, BCD_MS_MAX);

  // Time one second ahead of the current registers, with the full carry chain.
  always_comb begin
    logic sc_carry;
    logic mn_carry;
    n_hr_t   = hr_t;
    n_hr_u   = hr_u;
    n_mn_t   = mn_t;
    n_mn_u   = mn_u;
    n_sc_t   = sc_t;
    n_sc_u   = sc_u;
    sc_carry = 1'b0;
    mn_carry = 1'b0;

    if (sc_u != 4'd9) begin
      n_sc_u = sc_u + 4'd1;
    end else begin
      n_sc_u = 4'd0;
      if (sc_t != 4'd5) begin
        n_sc_t = sc_t + 4'd1;
      end else begin
        n_sc_t   = 4'd0;
        sc_carry = 1'b1;
      end
    end

    if (sc_carry) begin
      if (mn_u != 4'd9) begin
        n_mn_u = mn_u + 4'd1;
      end else begin
        n_mn_u = 4'd0;
        if (mn_t != 4'd5) begin
          n_mn_t = mn_t + 4'd1;
        end else begin
          n_mn_t   = 4'd0;
          mn_carry = 1'b1;
        end
      end
    end

    if (mn_carry) begin
      if ({hr_t, hr_u} == BCD_HH_MAX) begin
        n_hr_t = 4'd0;
        n_hr_u = 4'd0;
      end else if (hr_u == 4'd9) begin
        n_hr_t = hr_t + 4'd1;
        n_hr_u = 4'd0;
      end else begin
        n_hr_u = hr_u + 4'd1;
      end
    end
  end

  // The alarm compares against the time the advance is about to load.
  assign alarm_hit = alarm_en && alarm_ok &&
                     ({n_hr_t, n_hr_u} == alarm_hh) &&
                     ({n_mn_t, n_mn_u} == alarm_mm) &&
                     (n_sc_t == 4'd0) && (n_sc_u == 4'd0);

  // Prescaler, time registers and the one-cycle status pulses; a set wins over an advance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcnt      <= '0;
      hr_t      <= 4'd0;
      hr_u      <= 4'd0;
      mn_t      <= 4'd0;
      mn_u      <= 4'd0;
      sc_t      <= 4'd0;
      sc_u      <= 4'd0;
      tick_sec  <= 1'b0;
      alarm_irq <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      tick_sec  <= 1'b0;
      alarm_irq <= 1'b0;
      set_err   <= 1'b0;
      if (set_valid) begin
        if (set_ok) begin
          pcnt <= '0;
          hr_t <= set_hh[7:4];
          hr_u <= set_hh[3:0];
          mn_t <= set_mm[7:4];
          mn_u <= set_mm[3:0];
          sc_t <= set_ss[7:4];
          sc_u <= set_ss[3:0];
        end else begin
          // A rejected command freezes both the time and the prescaler.
          set_err <= 1'b1;
        end
      end else if (advance) begin
        pcnt      <= '0;
        hr_t      <= n_hr_t;
        hr_u      <= n_hr_u;
        mn_t      <= n_mn_t;
        mn_u      <= n_mn_u;
        sc_t      <= n_sc_t;
        sc_u      <= n_sc_u;
        tick_sec  <= 1'b1;
        alarm_irq <= alarm_hit;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  bcd_t disp_hr_t;
  bcd_t disp_hr_u;
  logic blank_hr_t;

  // Map the 24h hour to the displayed hour and pm flag; blank a leading zero in 12h mode.
  always_comb begin
    logic [7:0] hour;
    hour       = {hr_t, hr_u};
    disp_hr_t  = hr_t;
    disp_hr_u  = hr_u;
    pm         = 1'b0;
    blank_hr_t = 1'b0;
    if (mode_12h) begin
      if (hour == 8'h00) begin
        disp_hr_t = 4'd1;
        disp_hr_u = 4'd2;
      end else if (hour >= 8'h13) begin
        if (hour <= 8'h19) begin
          disp_hr_t = 4'd0;
          disp_hr_u = hr_u - 4'd2;
        end else if (hour <= 8'h21) begin
          disp_hr_t = 4'd0;
          disp_hr_u = hr_u + 4'd8;
        end else begin
          disp_hr_t = 4'd1;
          disp_hr_u = hr_u - 4'd2;
        end
      end
      pm         = (hour >= 8'h12);
      blank_hr_t = (disp_hr_t == 4'd0);
    end
  end

  bcd_to_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_hrm (
    .digit(disp_hr_t), .blank(blank_hr_t), .seg(hrm)
  );
  bcd_to_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_hrl (
    .digit(disp_hr_u), .blank(1'b0), .seg(hrl)
  );
  bcd_to_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_min_m (
    .digit(mn_t), .blank(1'b0), .seg(min_m)
  );
  bcd_to_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_min_l (
    .digit(mn_u), .blank(1'b0), .seg(min_l)
  );
  bcd_to_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_sec_m (
    .digit(sc_t), .blank(1'b0), .seg(sec_m)
  );
  bcd_to_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_sec_l (
    .digit(sc_u), .blank(1'b0), .seg(sec_l)
  );

endmodule
